// File: rtl/mux_share_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_share_arbiter_pkg                                        |
// | Description : Shared definitions for the two-port mux-sharing arbiter:     |
// |               arbiter state encodings, the reset value of the              |
// |               round-robin pointer, the hold-counter width, and a helper    |
// |               that maps a winning port index to its grant state.           |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mux_share_arbiter_pkg;

   // Arbiter states. Encodings are fixed so that other blocks and debug
   // tooling can decode a captured state word without this package.
   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_GRANT0 = 2'd1;
   localparam logic [1:0] c_GRANT1 = 2'd2;

   // After reset port 1 counts as the most recently served port, so port 0
   // wins the first simultaneous request.
   localparam logic c_LAST_SERVED_RST = 1'b1;

   // Hold counter width; covers the whole legal MAX_HOLD range (2..255).
   localparam int c_HOLD_W = 8;

   // Grant state that corresponds to a winning port index.
   function automatic logic [1:0] grant_state(input logic idx);
      return idx ? c_GRANT1 : c_GRANT0;
   endfunction

endpackage : mux_share_arbiter_pkg
`default_nettype wire

// File: rtl/mux_share_mux2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_share_mux2                                               |
// | Description : Single-bit 2:1 multiplexer cell used to build the shared     |
// |               selection path one data bit at a time.                       |
// | Ports       : a0 - input selected when s = 0                               |
// |               a1 - input selected when s = 1                               |
// |               s  - select                                                  |
// |               y  - selected output                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mux_share_mux2 (
   input  logic a0,
   input  logic a1,
   input  logic s,
   output logic y
);

   assign y = s ? a1 : a0;

endmodule : mux_share_mux2
`default_nettype wire

// File: rtl/mux_share_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_share_rr_pick                                            |
// | Description : Combinational two-way round-robin pick. With one request     |
// |               active that port wins; with both active the port that was    |
// |               not served last wins.                                        |
// | Ports       : req0, req1   - request lines                                 |
// |               last_served  - index of the most recently granted port       |
// |               win          - winning port index (valid when any = 1)       |
// |               any          - at least one request is active                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mux_share_rr_pick
   import mux_share_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_served,
   output logic win,
   output logic any
);

   always_comb begin
      any = req0 | req1;
      if (req0 && req1) begin
         win = ~last_served;
      end else begin
         // Single request (or none): the requesting port is port 1 exactly
         // when req1 is the active line. With no request the value is unused.
         win = req1;
      end
   end

endmodule : mux_share_rr_pick
`default_nettype wire

// File: rtl/mux_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_share_arbiter                                            |
// | Description : Round-robin arbiter sharing one 2:1 selection path between   |
// |               two requesters. Grants are registered and one-hot or zero;   |
// |               the word of the granted requester is captured into out_data  |
// |               one cycle after the requester sees its grant.                |
// | Parameters  : WIDTH    - data width (default 8)                            |
// |               MAX_HOLD - max consecutive grant cycles before a forced      |
// |                          handoff, 2..255 (default 4)                       |
// | Options     : MUX_SHARE_ARB_TIMEOUT_EN - when defined, a port that has     |
// |               held the grant for MAX_HOLD cycles yields to a waiting       |
// |               requester. When undefined, grants last while req is high.    |
// | Ports       : clock     - system clock, rising edge                        |
// |               resetn    - synchronous active-low reset                     |
// |               req0/req1 - requests from port 0 / port 1                    |
// |               data0/1   - request data from port 0 / port 1                |
// |               gnt0/gnt1 - registered grants                                |
// |               sel       - shared path select (0 = data0, 1 = data1)        |
// |               out_data  - registered selected word                         |
// |               out_valid - out_data holds a granted requester's word        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mux_share_arbiter
   import mux_share_arbiter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid
);

   // -------------------------------------------------------------------------
   // Elaboration-time parameter guard
   // -------------------------------------------------------------------------
   if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
      $error("mux_share_arbiter: MAX_HOLD must be in the range 2..255");
   end

   // -------------------------------------------------------------------------
   // Declarations
   // -------------------------------------------------------------------------
   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             r_last_served;
   logic             r_sel;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [WIDTH-1:0] w_mux;
   logic             w_win;
   logic             w_any;
   logic             w_cur_req;
   logic             w_xfer;
   logic             w_expire;

   // -------------------------------------------------------------------------
   // Round-robin pick, shared by the IDLE decision and by handoffs. While a
   // port holds the grant it is also last_served, so when its request drops
   // (or it times out) the pick naturally lands on the other port.
   // -------------------------------------------------------------------------
   mux_share_rr_pick u_pick (
      .req0        (req0),
      .req1        (req1),
      .last_served (r_last_served),
      .win         (w_win),
      .any         (w_any)
   );

   // -------------------------------------------------------------------------
   // Optional hold-limit logic
   // -------------------------------------------------------------------------
`ifdef MUX_SHARE_ARB_TIMEOUT_EN
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);

   logic [c_HOLD_W-1:0] r_hold;
   logic                w_other_req;

   assign w_other_req = (r_state == c_GRANT1) ? req0 : req1;
   // Yield only when someone is waiting; otherwise the grant continues with
   // the counter parked at its saturation value.
   assign w_expire    = (r_hold == c_HOLD_LAST) && w_other_req;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_hold <= '0;
      end else if ((w_next == c_IDLE) || (w_next != r_state)) begin
         // Cleared in IDLE and on every grant entry, including a direct
         // GRANT0 <-> GRANT1 handoff.
         r_hold <= '0;
      end else if (r_hold != c_HOLD_LAST) begin
         r_hold <= r_hold + 1'b1;
      end
   end
`else
   assign w_expire = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   assign w_cur_req = (r_state == c_GRANT1) ? req1 : req0;

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_any) begin
               w_next = grant_state(w_win);
            end
         end
         c_GRANT0, c_GRANT1: begin
            // Burst ends (or is forced to end): hand off directly to the
            // other port if it is waiting, otherwise fall back to IDLE.
            if (!w_cur_req || w_expire) begin
               w_next = w_any ? grant_state(w_win) : c_IDLE;
            end
         end
         default: begin
            w_next = c_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Shared data path: one mux cell per data bit
   // -------------------------------------------------------------------------
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      mux_share_mux2 u_mux (
         .a0 (data0[i]),
         .a1 (data1[i]),
         .s  (r_sel),
         .y  (w_mux[i])
      );
   end

   // A word is transferred only while the granted port still requests.
   assign w_xfer = ((r_state == c_GRANT0) && req0) ||
                   ((r_state == c_GRANT1) && req1);

   // -------------------------------------------------------------------------
   // State, select and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state       <= c_IDLE;
         r_last_served <= c_LAST_SERVED_RST;
         r_sel         <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
      end else begin
         r_state <= w_next;
         // sel tracks the grant state and keeps its last value in IDLE.
         if (w_next == c_GRANT0) begin
            r_sel         <= 1'b0;
            r_last_served <= 1'b0;
         end else if (w_next == c_GRANT1) begin
            r_sel         <= 1'b1;
            r_last_served <= 1'b1;
         end
         r_out_valid <= w_xfer;
         if (w_xfer) begin
            r_out_data <= w_mux;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign gnt0      = (r_state == c_GRANT0);
   assign gnt1      = (r_state == c_GRANT1);
   assign sel       = r_sel;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;

endmodule : mux_share_arbiter
`default_nettype wire

// File: tb/tb_mux_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mux_share_arbiter                                         |
// | Description : Self-checking bench for mux_share_arbiter. A transaction-    |
// |               level model (owner index, round-robin pointer, hold count)   |
// |               predicts every output each cycle; directed sequences add     |
// |               literal expectations, then a randomized run follows.         |
// |               Honors MUX_SHARE_ARB_TIMEOUT_EN for the hold-limit scenario. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mux_share_arbiter;

   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;

   logic             clock;
   logic             resetn;
   logic             req0, req1;
   logic [WIDTH-1:0] data0, data1;
   logic             gnt0, gnt1, sel, out_valid;
   logic [WIDTH-1:0] out_data;

   int vectors = 0;
   int errs    = 0;

   mux_share_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .req0      (req0),
      .req1      (req1),
      .data0     (data0),
      .data1     (data1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------------------------------------------------------------
   // Reference model: who owns the path (-1 none), who was served last,
   // how long the owner has held it, and the output register contents.
   // ---------------------------------------------------------------------
   int               m_owner = -1;
   int               m_last  = 1;
   int               m_hold  = 0;
   int               m_sel   = 0;
   logic             m_valid = 1'b0;
   logic [WIDTH-1:0] m_data  = '0;

   function automatic void model_step(input logic rn, input logic r0, input logic r1,
                                      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
      int  req[2];
      int  nxt;
      bit  keep;
      req[0] = r0;
      req[1] = r1;
      if (!rn) begin
         m_owner = -1; m_last = 1; m_hold = 0; m_sel = 0;
         m_valid = 1'b0; m_data = '0;
         return;
      end
      // Output register sees the current owner and its request.
      m_valid = (m_owner >= 0) && (req[m_owner] == 1);
      if (m_valid) m_data = (m_owner == 1) ? d1 : d0;
      // Ownership for the next cycle.
      if (m_owner < 0) begin
         if (r0 && r1)  nxt = 1 - m_last;
         else if (r0)   nxt = 0;
         else if (r1)   nxt = 1;
         else           nxt = -1;
      end else begin
         keep = (req[m_owner] == 1);
`ifdef MUX_SHARE_ARB_TIMEOUT_EN
         if (keep && (m_hold == MAX_HOLD - 1) && (req[1 - m_owner] == 1)) keep = 0;
`endif
         if (keep)                           nxt = m_owner;
         else if (req[1 - m_owner] == 1)     nxt = 1 - m_owner;
         else                                nxt = -1;
      end
      if ((nxt < 0) || (nxt != m_owner)) m_hold = 0;
      else if (m_hold < MAX_HOLD - 1)    m_hold = m_hold + 1;
      if ((nxt >= 0) && (nxt != m_owner)) m_last = nxt;
      if (nxt >= 0) m_sel = nxt;
      m_owner = nxt;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("gnt0",      32'(gnt0),      32'(m_owner == 0));
      chk("gnt1",      32'(gnt1),      32'(m_owner == 1));
      chk("sel",       32'(sel),       32'(m_sel));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data",  32'(out_data),  32'(m_data));
      chk("onehot",    32'(gnt0 & gnt1), 32'd0);
   endtask

   // Apply one cycle of inputs, advance the model at the edge, check #1 later.
   task automatic tick(input logic rn, input logic r0, input logic r1,
                       input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
      resetn = rn; req0 = r0; req1 = r1; data0 = d0; data1 = d1;
      @(posedge clock);
      model_step(rn, r0, r1, d0, d1);
      #1;
      compare_all();
   endtask

   initial begin
      resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;

      // Reset held two cycles with both requests high.
      tick(0, 1, 1, 8'h5A, 8'h3C);
      tick(0, 1, 1, 8'h5A, 8'h3C);
      chk("rst_gnt0", 32'(gnt0), 0);
      chk("rst_gnt1", 32'(gnt1), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_sel", 32'(sel), 0);

      // Single requester.
      tick(1, 1, 0, 8'hA5, 8'h00);
      chk("single_gnt0", 32'(gnt0), 1);
      chk("single_valid0", 32'(out_valid), 0);
      tick(1, 1, 0, 8'hA5, 8'h00);
      chk("single_valid", 32'(out_valid), 1);
      chk("single_data", 32'(out_data), 32'hA5);
      tick(1, 1, 0, 8'hA5, 8'h00);
      tick(1, 0, 0, 8'hA5, 8'h00);
      chk("single_idle", 32'(gnt0), 0);
      chk("single_novalid", 32'(out_valid), 0);
      chk("single_hold", 32'(out_data), 32'hA5);

      // Tie right after reset: port 0 first, then direct handoff to port 1.
      tick(0, 0, 0, 8'h00, 8'h00);
      tick(1, 1, 1, 8'h11, 8'h22);
      chk("tie_gnt0", 32'(gnt0), 1);
      tick(1, 1, 1, 8'h11, 8'h22);
      chk("tie_data0", 32'(out_data), 32'h11);
      chk("tie_valid0", 32'(out_valid), 1);
      tick(1, 0, 1, 8'h11, 8'h22);
      chk("tie_handoff", {gnt1, gnt0}, 2'b10);
      tick(1, 0, 1, 8'h11, 8'h22);
      chk("tie_data1", 32'(out_data), 32'h22);
      chk("tie_sel1", 32'(sel), 1);

      // Fairness: requests pulse alternately, grants must alternate.
      tick(1, 0, 0, 8'h00, 8'h00);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) tick(1, 1, 0, 8'(i), 8'(i + 8'h40));
         else            tick(1, 0, 1, 8'(i), 8'(i + 8'h40));
         chk("fair_alt", {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end

      // Hold limit: req0 held, req1 raised one cycle after gnt0 appears.
      tick(0, 0, 0, 8'h00, 8'h00);
      tick(1, 1, 0, 8'h77, 8'h88);
      chk("to_gnt0_c1", 32'(gnt0), 1);
      for (int i = 2; i <= 4; i++) begin
         tick(1, 1, 1, 8'h77, 8'h88);
         chk("to_gnt0_hold", 32'(gnt0), 1);
      end
      tick(1, 1, 1, 8'h77, 8'h88);
`ifdef MUX_SHARE_ARB_TIMEOUT_EN
      chk("to_switch", {sel, gnt1, gnt0}, 3'b110);
`else
      chk("to_persist", {sel, gnt1, gnt0}, 3'b001);
      tick(1, 1, 1, 8'h77, 8'h88);
      tick(1, 1, 1, 8'h77, 8'h88);
      chk("to_persist2", 32'(gnt0), 1);
      tick(1, 0, 1, 8'h77, 8'h88);
      chk("to_release", {sel, gnt1, gnt0}, 3'b110);
`endif

      // Mid-burst reset while port 1 holds the grant.
      tick(0, 0, 0, 8'h00, 8'h00);
      tick(1, 0, 1, 8'h12, 8'h34);
      tick(1, 0, 1, 8'h12, 8'h34);
      chk("mb_gnt1", 32'(gnt1), 1);
      tick(0, 1, 1, 8'h12, 8'h34);
      chk("mb_gnt1_drop", 32'(gnt1), 0);
      chk("mb_valid_drop", 32'(out_valid), 0);
      tick(1, 1, 1, 8'h12, 8'h34);
      chk("mb_port0", {gnt1, gnt0}, 2'b01);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic rn, r0, r1;
         rn = ($urandom_range(0, 99) >= 2);
         r0 = ($urandom_range(0, 99) < 60);
         r1 = ($urandom_range(0, 99) < 55);
         tick(rn, r0, r1, 8'($urandom), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule : tb_mux_share_arbiter
`default_nettype wire
